// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the write-back stage and register file.
// Used by MEM_WB and by wb_regfile; replaces the old define.v macros.
package wb_regfile_pkg;

    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 12;
    localparam int REG_ADDR_W = 4;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        WB_DATA_OP_ALU = 2'd0,
        WB_DATA_OP_RAM = 2'd1,
        WB_DATA_OP_PC  = 2'd2,
        WB_DATA_OP_IH  = 2'd3
    } wb_data_op_e;

    // Only WRITE is meaningful; every other encoding behaves as NOP.
    localparam logic [1:0] REG_OP_NOP   = 2'd0;
    localparam logic [1:0] REG_OP_WRITE = 2'd1;

    localparam reg_addr_t REG_SP = 4'd8;
    localparam reg_addr_t REG_IH = 4'd9;
    localparam reg_addr_t REG_T  = 4'd10;
    localparam reg_addr_t REG_RA = 4'd11;

    localparam reg_addr_t NUM_REGS_A = reg_addr_t'(NUM_REGS);

    function automatic logic reg_implemented(reg_addr_t addr);
        return addr < NUM_REGS_A;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB pipeline bundle: the MEM_WB latch drives it (master) and the
// write-back stage consumes it every cycle with no handshake (slave).
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    wb_data_op_e mw_WB_data_op;
    logic [1:0]  mw_REG_op;
    data_t       mw_IH;
    data_t       mw_PC;
    data_t       mw_ALU_data;
    data_t       mw_RAM_data;
    reg_addr_t   mw_WB_addr;

    modport master (
        output mw_WB_data_op, mw_REG_op, mw_IH, mw_PC,
               mw_ALU_data, mw_RAM_data, mw_WB_addr
    );

    modport slave (
        input mw_WB_data_op, mw_REG_op, mw_IH, mw_PC,
              mw_ALU_data, mw_RAM_data, mw_WB_addr
    );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Combinational 4:1 write-back source select; also instantiated by the
// forwarding path so both see the identical selected value.
module wb_mux
    import wb_regfile_pkg::*;
(
    input  wb_data_op_e sel_i,
    input  data_t       alu_i,
    input  data_t       ram_i,
    input  data_t       pc_i,
    input  data_t       ih_i,
    output data_t       data_o
);

    always_comb begin
        data_o = alu_i;
        case (sel_i)
            WB_DATA_OP_ALU: data_o = alu_i;
            WB_DATA_OP_RAM: data_o = ram_i;
            WB_DATA_OP_PC:  data_o = pc_i;
            WB_DATA_OP_IH:  data_o = ih_i;
            default:        data_o = alu_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 12-entry architectural register file with two read
// ports and SP/IH/T taps. Define WB_REGFILE_BYPASS_EN for write-through reads.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic         clk_50MHz,
    input  logic         rst,
    wb_regfile_if.slave  mw,
    input  reg_addr_t    rd_addr_a,
    input  reg_addr_t    rd_addr_b,
    output data_t        rd_data_a,
    output data_t        rd_data_b,
    output data_t        reg_SP,
    output data_t        reg_IH,
    output data_t        reg_T,
    output data_t        wb_count
);

    data_t wb_data;
    logic  commit;

    data_t regs_q [NUM_REGS];
    data_t regs_d [NUM_REGS];
    data_t cnt_q;
    data_t cnt_d;

    wb_mux u_wb_mux (
        .sel_i  (mw.mw_WB_data_op),
        .alu_i  (mw.mw_ALU_data),
        .ram_i  (mw.mw_RAM_data),
        .pc_i   (mw.mw_PC),
        .ih_i   (mw.mw_IH),
        .data_o (wb_data)
    );

    // Gating with rst keeps the bypass path quiet while reset is held.
    assign commit = !rst && (mw.mw_REG_op == REG_OP_WRITE)
                    && reg_implemented(mw.mw_WB_addr);

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (commit) begin
            regs_d[mw.mw_WB_addr] = wb_data;
            cnt_d                 = cnt_q + data_t'(1);
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (reg_implemented(rd_addr_a)) begin
            rd_data_a = regs_q[rd_addr_a];
        end
        if (reg_implemented(rd_addr_b)) begin
            rd_data_b = regs_q[rd_addr_b];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (rd_addr_a == mw.mw_WB_addr)) begin
            rd_data_a = wb_data;
        end
        if (commit && (rd_addr_b == mw.mw_WB_addr)) begin
            rd_data_b = wb_data;
        end
`endif
    end

    // Taps show stored state only, never the bypassed value.
    assign reg_SP   = regs_q[REG_SP];
    assign reg_IH   = regs_q[REG_IH];
    assign reg_T    = regs_q[REG_T];
    assign wb_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: random mw_* traffic against an array-based reference
// model, plus directed literal checks for reset, taps, RAW, wrap and reset.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

`ifdef WB_REGFILE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk_50MHz = 1'b0;
    logic        rst;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a, rd_data_b, reg_SP, reg_IH, reg_T, wb_count;

    wb_regfile_if mw ();

    wb_regfile dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .mw        (mw),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .reg_SP    (reg_SP),
        .reg_IH    (reg_IH),
        .reg_T     (reg_T),
        .wb_count  (wb_count)
    );

    // ---------------- clock ----------------
    always #5 clk_50MHz = ~clk_50MHz;

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    bit          cmp_en = 1'b0;
    logic [15:0] m_regs [16];
    logic [15:0] m_count;
    logic [15:0] m_cnt_off = 16'h0000;
    logic [15:0] exp_q [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_wb_data();
        logic [15:0] cand [4];
        cand[0] = mw.mw_ALU_data;
        cand[1] = mw.mw_RAM_data;
        cand[2] = mw.mw_PC;
        cand[3] = mw.mw_IH;
        return cand[mw.mw_WB_data_op];
    endfunction

    function automatic logic m_commit();
        return (rst === 1'b0) && (mw.mw_REG_op == 2'd1) && (int'(mw.mw_WB_addr) < 12);
    endfunction

    function automatic logic [15:0] m_read(input logic [3:0] addr);
        if (BYP && m_commit() && addr == mw.mw_WB_addr) return m_wb_data();
        return m_regs[addr];
    endfunction

    always @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] <= 16'h0000;
            m_count <= 16'h0000;
        end else if (m_commit()) begin
            m_regs[mw.mw_WB_addr] <= m_wb_data();
            m_count <= m_count + 16'h0001;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk_50MHz) begin
        if (cmp_en) begin
            chk("rd_data_a", rd_data_a, m_read(rd_addr_a));
            chk("rd_data_b", rd_data_b, m_read(rd_addr_b));
            chk("reg_SP", reg_SP, m_regs[8]);
            chk("reg_IH", reg_IH, m_regs[9]);
            chk("reg_T", reg_T, m_regs[10]);
            chk("wb_count", wb_count, m_count + m_cnt_off);
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input logic [1:0] op, input logic [1:0] regop, input logic [3:0] addr,
                        input logic [15:0] alu, input logic [15:0] ram, input logic [15:0] pc,
                        input logic [15:0] ih, input logic [3:0] ra, input logic [3:0] rb);
        @(posedge clk_50MHz);
        #1;
        mw.mw_WB_data_op = wb_data_op_e'(op);
        mw.mw_REG_op     = regop;
        mw.mw_WB_addr    = addr;
        mw.mw_ALU_data   = alu;
        mw.mw_RAM_data   = ram;
        mw.mw_PC         = pc;
        mw.mw_IH         = ih;
        rd_addr_a        = ra;
        rd_addr_b        = rb;
    endtask

    task automatic nop(input logic [3:0] ra, input logic [3:0] rb);
        step(2'd0, 2'd0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0, ra, rb);
    endtask

    task automatic rand_step(input bit force_write);
        logic [1:0] regop;
        logic [3:0] addr;
        logic [3:0] ra, rb;
        addr  = 4'($urandom_range(0, 15));
        regop = (force_write || $urandom_range(0, 9) < 6) ? 2'd1 : 2'($urandom_range(0, 3));
        ra    = ($urandom_range(0, 1) == 0) ? addr : 4'($urandom_range(0, 15));
        rb    = ($urandom_range(0, 1) == 0) ? addr : 4'($urandom_range(0, 15));
        step(2'($urandom_range(0, 3)), regop, addr,
             16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), ra, rb);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst              = 1'b1;
        mw.mw_WB_data_op = WB_DATA_OP_RAM;
        mw.mw_REG_op     = 2'd1;
        mw.mw_WB_addr    = 4'd5;
        mw.mw_ALU_data   = 16'($urandom);
        mw.mw_RAM_data   = 16'($urandom);
        mw.mw_PC         = 16'($urandom);
        mw.mw_IH         = 16'($urandom);
        rd_addr_a        = 4'd5;
        rd_addr_b        = 4'd8;

        // Reset held with a write pending: everything must read zero.
        @(posedge clk_50MHz);
        cmp_en = 1'b1;
        @(negedge clk_50MHz);
        chk("rst_rd_a", rd_data_a, 16'h0000);
        chk("rst_rd_b", rd_data_b, 16'h0000);
        chk("rst_count", wb_count, 16'h0000);
        chk("rst_sp", reg_SP, 16'h0000);

        @(posedge clk_50MHz);
        #1;
        rst          = 1'b0;
        mw.mw_REG_op = 2'd0;
        for (int i = 0; i < 3; i++) begin
            nop(4'd5, 4'd10);
            @(negedge clk_50MHz);
            chk("post_rst_count", wb_count, 16'h0000);
            chk("post_rst_rd_a", rd_data_a, 16'h0000);
        end

        // Source select on R3.
        for (int k = 0; k < 4; k++) begin
            step(k[1:0], 2'd1, 4'd3, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'd0, 4'd0);
            exp_q.push_back(16'(16'h1111 * (k + 1)));
            nop(4'd3, 4'd3);
            @(negedge clk_50MHz);
            chk("src_sel", rd_data_a, exp_q.pop_front());
        end
        chk("src_count", wb_count, 16'd4);

        // Taps and dropped write.
        step(2'd0, 2'd1, 4'd8, 16'hBEEF, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0);
        nop(4'd8, 4'd9);
        @(negedge clk_50MHz);
        chk("tap_sp", reg_SP, 16'hBEEF);
        step(2'd1, 2'd1, 4'd9, 16'h0, 16'hCAFE, 16'h0, 16'h0, 4'd0, 4'd0);
        nop(4'd8, 4'd9);
        @(negedge clk_50MHz);
        chk("tap_ih", reg_IH, 16'hCAFE);
        step(2'd0, 2'd1, 4'd13, 16'h7777, 16'h0, 16'h0, 16'h0, 4'd13, 4'd13);
        @(negedge clk_50MHz);
        chk("drop_rd_bypass", rd_data_a, 16'h0000);
        nop(4'd13, 4'd8);
        @(negedge clk_50MHz);
        chk("drop_count", wb_count, 16'd6);
        chk("drop_rd", rd_data_a, 16'h0000);
        chk("drop_sp", reg_SP, 16'hBEEF);
        chk("drop_ih", reg_IH, 16'hCAFE);

        // Same-cycle read-after-write on R5.
        step(2'd0, 2'd1, 4'd5, 16'h0001, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0);
        step(2'd0, 2'd1, 4'd5, 16'h5A5A, 16'h0, 16'h0, 16'h0, 4'd5, 4'd5);
        @(negedge clk_50MHz);
        chk("raw_same_a", rd_data_a, BYP ? 16'h5A5A : 16'h0001);
        chk("raw_same_b", rd_data_b, BYP ? 16'h5A5A : 16'h0001);
        nop(4'd5, 4'd5);
        @(negedge clk_50MHz);
        chk("raw_next_a", rd_data_a, 16'h5A5A);
        chk("raw_next_b", rd_data_b, 16'h5A5A);
        chk("raw_count", wb_count, 16'd8);

        // Counter wrap: preload the count to 0xFFFF, then one more commit.
        #2;
        force dut.cnt_q = 16'hFFFF;
        m_cnt_off = 16'hFFFF - m_count;
        #1;
        release dut.cnt_q;
        step(2'd2, 2'd1, 4'd0, 16'h0, 16'h0, 16'h1234, 16'h0, 4'd0, 4'd0);
        @(negedge clk_50MHz);
        chk("wrap_pre", wb_count, 16'hFFFF);
        nop(4'd0, 4'd0);
        @(negedge clk_50MHz);
        chk("wrap_post", wb_count, 16'h0000);
        chk("wrap_r0", rd_data_a, 16'h1234);

        for (int i = 0; i < 400; i++) rand_step(1'b0);

        // Asynchronous reset between edges during back-to-back writes.
        for (int i = 0; i < 6; i++) rand_step(1'b1);
        mw.mw_REG_op  = 2'd1;
        mw.mw_WB_addr = 4'd8;
        #2;
        rst       = 1'b1;
        m_cnt_off = 16'h0000;
        #1;
        chk("async_count", wb_count, 16'h0000);
        chk("async_sp", reg_SP, 16'h0000);
        @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        chk("held_count", wb_count, 16'h0000);
        chk("held_sp", reg_SP, 16'h0000);
        #1;
        rst          = 1'b0;
        mw.mw_REG_op = 2'd0;
        nop(4'd8, 4'd0);
        @(negedge clk_50MHz);
        chk("release_count", wb_count, 16'h0000);

        for (int i = 0; i < 200; i++) rand_step(1'b0);
        @(negedge clk_50MHz);
        #1;
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
